uart_bus_master: RTL and testbench



---
 rtl/uart_bus_master.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// UART debug bridge: 'R'/'W' command frames become single-word accesses on the native memory bus.
// Define UART_BUS_MASTER_TIMEOUT_EN to abandon an access after TIMEOUT cycles and reply 'T'.
module uart_bus_master #(
  parameter int unsigned CLK_DIV = 104,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] FullCnt = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLK_DIV / 2 - 1);

  localparam logic [7:0] CmdRead    = 8'h52;
  localparam logic [7:0] CmdWrite   = 8'h57;
  localparam logic [7:0] RepWrite   = 8'h4B;
  localparam logic [7:0] RepUnknown = 8'h3F;

  typedef enum logic [2:0] {StIdle, StAddr, StData, StBus, StReply} state_e;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic            rx_busy_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [3:0]      rx_bit_q;
  logic [7:0]      rx_sh_q;
  logic            rx_tick, rx_done, rx_ferr;

  state_e          state_q;
  logic            is_write_q;
  logic [1:0]      idx_q;
  logic [31:0]     addr_q;
  logic [31:0]     reply_q;
  logic [2:0]      tx_left_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [3:0]      tx_bit_q;
  logic [7:0]      tx_byte;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  logic [ToW-1:0] to_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  assign mem_instr = 1'b0;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign tx_byte   = reply_q[31:24];

  // Bit 0 is the start bit, checked half a bit in; bits 1..8 are data, bit 9 is stop.
  assign rx_tick = rx_busy_q && (rx_cnt_q == ((rx_bit_q == 4'd0) ? HalfCnt : FullCnt));
  assign rx_done = rx_tick && (rx_bit_q == 4'd9) && rx_sync_q;
  assign rx_ferr = rx_tick && (rx_bit_q == 4'd9) && !rx_sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_busy_q <= 1'b0;
      rx_cnt_q  <= '0;
      rx_bit_q  <= 4'd0;
      rx_sh_q   <= 8'h00;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      if (!rx_busy_q) begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= '0;
          rx_bit_q  <= 4'd0;
        end
      end else if (rx_tick) begin
        rx_cnt_q <= '0;
        if ((rx_bit_q == 4'd0) && rx_sync_q) begin
          rx_busy_q <= 1'b0;  // start bit vanished: glitch
        end else if (rx_bit_q == 4'd9) begin
          rx_busy_q <= 1'b0;
        end else begin
          rx_bit_q <= rx_bit_q + 4'd1;
          if (rx_bit_q != 4'd0) rx_sh_q <= {rx_sync_q, rx_sh_q[7:1]};
        end
      end else begin
        rx_cnt_q <= rx_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      is_write_q <= 1'b0;
      idx_q      <= 2'd0;
      addr_q     <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wstrb  <= 4'h0;
      mem_valid  <= 1'b0;
      busy       <= 1'b0;
      uart_tx    <= 1'b1;
      reply_q    <= 32'h0;
      tx_left_q  <= 3'd0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 4'd0;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
`ifdef UART_BUS_MASTER_TIMEOUT_EN
      if (state_q != StBus) to_cnt_q <= '0;
`endif
      unique case (state_q)
        StIdle: begin
          if (rx_done) begin
            if ((rx_sh_q == CmdRead) || (rx_sh_q == CmdWrite)) begin
              is_write_q <= (rx_sh_q == CmdWrite);
              idx_q      <= 2'd0;
              state_q    <= StAddr;
            end else begin
              reply_q   <= {RepUnknown, 24'h0};
              tx_left_q <= 3'd1;
              uart_tx   <= 1'b0;
              tx_cnt_q  <= '0;
              tx_bit_q  <= 4'd0;
              state_q   <= StReply;
            end
          end
        end
        StAddr: begin
          if (rx_done) begin
            addr_q <= {addr_q[23:0], rx_sh_q};
            busy   <= 1'b1;
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              if (is_write_q) begin
                state_q <= StData;
              end else begin
                mem_wstrb <= 4'h0;
                mem_valid <= 1'b1;
                state_q   <= StBus;
              end
            end
          end else if (rx_ferr) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StData: begin
          if (rx_done) begin
            mem_wdata <= {mem_wdata[23:0], rx_sh_q};
            idx_q     <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              mem_wstrb <= 4'hF;
              mem_valid <= 1'b1;
              state_q   <= StBus;
            end
          end else if (rx_ferr) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StBus: begin
          // mem_ready is checked first so it beats a timeout expiring in the same cycle.
          if (mem_ready) begin
            mem_valid <= 1'b0;
            reply_q   <= is_write_q ? {RepWrite, 24'h0} : mem_rdata;
            tx_left_q <= is_write_q ? 3'd1 : 3'd4;
            uart_tx   <= 1'b0;
            tx_cnt_q  <= '0;
            tx_bit_q  <= 4'd0;
            state_q   <= StReply;
          end
`ifdef UART_BUS_MASTER_TIMEOUT_EN
          else if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
            mem_valid <= 1'b0;
            reply_q   <= {8'h54, 24'h0};
            tx_left_q <= 3'd1;
            uart_tx   <= 1'b0;
            tx_cnt_q  <= '0;
            tx_bit_q  <= 4'd0;
            state_q   <= StReply;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        StReply: begin
          if (tx_cnt_q == FullCnt) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
              if (tx_left_q != 3'd1) begin
                tx_left_q <= tx_left_q - 3'd1;
                reply_q   <= {reply_q[23:0], 8'h00};
                uart_tx   <= 1'b0;
                tx_bit_q  <= 4'd0;
              end else begin
                uart_tx <= 1'b1;
                busy    <= 1'b0;
                state_q <= StIdle;
              end
            end else begin
              tx_bit_q <= tx_bit_q + 4'd1;
              uart_tx  <= (tx_bit_q < 4'd8) ? tx_byte[tx_bit_q[2:0]] : 1'b1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: host-side UART driver/decoder and a 2-cycle-latency memory.
`timescale 1ns/1ps
module tb_uart_bus_master;

  localparam int unsigned ClkDiv  = 8;
  localparam int unsigned Timeout = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        mem_valid, mem_instr, mem_ready, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        resp_en = 1'b1;

  logic [31:0] mem [16];
  int          lat = 0;
  int          hs_cnt = 0;
  int          valid_cycles = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  logic [7:0]  rx_q [$];
  int          tx_stop_err = 0;

  int vec_cnt = 0;
  int miss_cnt = 0;

  typedef struct packed {
    logic [71:0] cmd;
    int          ncmd;
    int          hs;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rep;
    int          nrep;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  uart_bus_master #(
    .CLK_DIV (ClkDiv),
    .TIMEOUT (Timeout)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Responder: ready two cycles after mem_valid rises.
  assign mem_ready = resp_en && mem_valid && (lat >= 2);
  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'h11223344;
      mem[12] <= 32'hCAFEF00D;
      lat     <= 0;
    end else begin
      lat <= (mem_valid && !mem_ready) ? lat + 1 : 0;
      if (mem_valid) valid_cycles <= valid_cycles + 1;
      if (mem_valid && mem_ready) begin
        hs_cnt    <= hs_cnt + 1;
        cap_addr  <= mem_addr;
        cap_wdata <= mem_wdata;
        cap_wstrb <= mem_wstrb;
        if (mem_wstrb == 4'hF) mem[mem_addr[5:2]] <= mem_wdata;
      end
    end
  end

  // Host receiver: samples uart_tx mid-bit on falling clock edges.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (resetn && (uart_tx === 1'b0)) begin
        repeat (ClkDiv / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (ClkDiv) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (ClkDiv) @(negedge clk);
        if (uart_tx !== 1'b1) tx_stop_err = tx_stop_err + 1;
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick(ClkDiv);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(ClkDiv);
    end
    uart_rx = stop;
    tick(ClkDiv);
    uart_rx = 1'b1;
    tick(ClkDiv);
  endtask

  task automatic send_frame(input logic [71:0] c, input int n);
    for (int i = 0; i < n; i++) send_byte(c[71-8*i -: 8], 1'b1);
  endtask

  function automatic logic [7:0] got_byte(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
  endfunction

  // Bounded wait for n reply bytes, then a quiet period so extra bytes would show up.
  task automatic wait_bytes(input int base, input int n);
    int t;
    t = 0;
    while ((rx_q.size() < base + n) && (t < 4000)) begin
      tick(1);
      t++;
    end
    tick(30 * ClkDiv);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          base, hs0, vc0;
    logic [31:0] r;
    base = rx_q.size();
    hs0  = hs_cnt;
    vc0  = valid_cycles;
    r    = v.rep;
    send_frame(v.cmd, v.ncmd);
    wait_bytes(base, v.nrep);
    check({tag, " reply count"}, rx_q.size() - base, v.nrep);
    for (int k = 0; k < v.nrep; k++)
      check($sformatf("%s reply byte %0d", tag, k), got_byte(base + k), r[31-8*k -: 8]);
    check({tag, " handshakes"}, hs_cnt - hs0, v.hs);
    check({tag, " mem_valid cycles"}, valid_cycles - vc0, (v.hs != 0) ? 3 : 0);
    if (v.hs != 0) begin
      check({tag, " mem_addr"}, cap_addr, v.addr);
      check({tag, " mem_wstrb"}, cap_wstrb, v.wstrb);
      if (v.wstrb == 4'hF) check({tag, " mem_wdata"}, cap_wdata, v.wdata);
    end
    check({tag, " busy idle"}, busy, 1'b0);
    check({tag, " uart_tx idle"}, uart_tx, 1'b1);
  endtask

  initial begin
    int base, hs0, vc0, t;

    vecs[0] = '{cmd: 72'h57_00000020_DEADBEEF, ncmd: 9, hs: 1, addr: 32'h20,
                wdata: 32'hDEADBEEF, wstrb: 4'hF, rep: 32'h4B000000, nrep: 1};
    vecs[1] = '{cmd: 72'h52_00000010_00000000, ncmd: 5, hs: 1, addr: 32'h10,
                wdata: 32'h0, wstrb: 4'h0, rep: 32'h11223344, nrep: 4};
    vecs[2] = '{cmd: 72'h52_00000013_00000000, ncmd: 5, hs: 1, addr: 32'h10,
                wdata: 32'h0, wstrb: 4'h0, rep: 32'h11223344, nrep: 4};
    vecs[3] = '{cmd: 72'h41_00000000_00000000, ncmd: 1, hs: 0, addr: 32'h0,
                wdata: 32'h0, wstrb: 4'h0, rep: 32'h3F000000, nrep: 1};
    vecs[4] = '{cmd: 72'h52_00000020_00000000, ncmd: 5, hs: 1, addr: 32'h20,
                wdata: 32'h0, wstrb: 4'h0, rep: 32'hDEADBEEF, nrep: 4};
    vecs[5] = '{cmd: 72'h57_00000024_01020304, ncmd: 9, hs: 1, addr: 32'h24,
                wdata: 32'h01020304, wstrb: 4'hF, rep: 32'h4B000000, nrep: 1};
    vecs[6] = '{cmd: 72'h52_00000024_00000000, ncmd: 5, hs: 1, addr: 32'h24,
                wdata: 32'h0, wstrb: 4'h0, rep: 32'h01020304, nrep: 4};

    tick(5);
    check("reset uart_tx", uart_tx, 1'b1);
    check("reset mem_valid", mem_valid, 1'b0);
    resetn = 1'b1;
    tick(3);
    check("idle uart_tx", uart_tx, 1'b1);
    check("idle mem_valid", mem_valid, 1'b0);
    check("idle mem_instr", mem_instr, 1'b0);
    check("idle busy", busy, 1'b0);
    check("idle mem_addr", mem_addr, 32'h0);
    check("idle mem_wdata", mem_wdata, 32'h0);
    check("idle mem_wstrb", mem_wstrb, 4'h0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Framing error in the middle of the address.
    base = rx_q.size();
    hs0  = hs_cnt;
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    check("busy after first address byte", busy, 1'b1);
    send_byte(8'h00, 1'b0);
    tick(2 * ClkDiv);
    check("busy after framing error", busy, 1'b0);
    wait_bytes(base, 0);
    check("framing error reply count", rx_q.size() - base, 0);
    check("framing error handshakes", hs_cnt - hs0, 0);
    run_vec(vecs[1], "read after framing error");

    // Responder never ready.
    resp_en = 1'b0;
    base = rx_q.size();
    hs0  = hs_cnt;
    vc0  = valid_cycles;
    send_frame(72'h52_00000030_00000000, 5);
`ifdef UART_BUS_MASTER_TIMEOUT_EN
    wait_bytes(base, 1);
    check("timeout mem_valid cycles", valid_cycles - vc0, Timeout);
    check("timeout handshakes", hs_cnt - hs0, 0);
    check("timeout reply count", rx_q.size() - base, 1);
    check("timeout reply byte", got_byte(base), 8'h54);
    check("timeout mem_valid low", mem_valid, 1'b0);
    resp_en = 1'b1;
`else
    tick(40);
    check("stall mem_valid held", mem_valid, 1'b1);
    check("stall mem_addr", mem_addr, 32'h30);
    check("stall no reply yet", rx_q.size() - base, 0);
    resp_en = 1'b1;
    wait_bytes(base, 4);
    check("stall handshakes", hs_cnt - hs0, 1);
    check("stall reply count", rx_q.size() - base, 4);
    check("stall reply byte 0", got_byte(base), 8'hCA);
    check("stall reply byte 3", got_byte(base + 3), 8'h0D);
`endif

    // Reset during the second reply byte of a read.
    base = rx_q.size();
    send_frame(72'h52_00000010_00000000, 5);
    t = 0;
    while ((rx_q.size() < base + 1) && (t < 4000)) begin
      tick(1);
      t++;
    end
    check("pre-reset first reply byte", got_byte(base), 8'h11);
    tick(3 * ClkDiv);
    check("busy mid reply", busy, 1'b1);
    resetn = 1'b0;
    #1;
    check("async reset uart_tx", uart_tx, 1'b1);
    check("async reset busy", busy, 1'b0);
    check("async reset mem_valid", mem_valid, 1'b0);
    tick(4);
    resetn = 1'b1;
    tick(20 * ClkDiv);
    run_vec(vecs[5], "write after reset");
    run_vec(vecs[6], "readback after reset");

    check("tx stop bit errors", tx_stop_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
